// File: rtl/vp_isa_pkg.sv
// Instruction-set definitions for the vector processor: opcode enum,
// field positions, packed instruction layout and the encode/legality helpers.
// The program loader and the control unit both use this package.
package vp_isa_pkg;

   // Fixed by the ISA; the loader does not expose it as a parameter.
   localparam int INSTR_W = 21;

   // Bit positions shared by both instruction formats
   localparam int FUNCT_POS   = 20;
   localparam int OPCODE_LSB  = 17;
   localparam int IMM_SEL_POS = 16;
   localparam int WB_LSB      = 14;
   // Scalar format body
   localparam int S_RD_LSB    = 10;
   localparam int S_IMM_LSB   = 0;
   // Vector / load-store format body
   localparam int V_RD_LSB    = 11;
   localparam int V_RS1_LSB   = 8;
   localparam int V_RS2_LSB   = 5;

   typedef enum logic [2:0] {
      MOV_S  = 3'b000,
      MOV_SV = 3'b001,
      ADD_S  = 3'b010,
      SUB_S  = 3'b011,
      MUL_VS = 3'b100,
      ADD_VV = 3'b101,
      DIV_VS = 3'b110
   } opcode_e;

   // Common header followed by a format-dependent 14-bit body
   typedef struct packed {
      logic        funct;
      logic [2:0]  opcode;
      logic        imm_sel;
      logic [1:0]  wb;
      logic [13:0] body;
   } instr_t;

   // Loader session states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } load_state_t;

   // Scalar format applies only to non-load/store MOV_S, ADD_S and SUB_S
   function automatic logic is_scalar(input logic funct, input logic [2:0] opcode);
      return !funct && (opcode == MOV_S || opcode == ADD_S || opcode == SUB_S);
   endfunction

   function automatic logic [INSTR_W-1:0] encode_instr(
      input logic       funct,
      input logic [2:0] opcode,
      input logic       imm_sel,
      input logic [1:0] wb,
      input logic [3:0] rd,
      input logic [2:0] rs1,
      input logic [2:0] rs2,
      input logic [7:0] imm
   );
      instr_t w;
      w.funct   = funct;
      w.opcode  = opcode;
      w.imm_sel = imm_sel;
      w.wb      = wb;
      if (is_scalar(funct, opcode)) begin
         w.body = {rd, 2'b00, imm};
      end else begin
         // Vector registers are 3 bits wide, so rd[3] has no place here
         w.body = {rd[2:0], rs1, rs2, 5'b00000};
      end
      return w;
   endfunction

   // Unassigned opcode, or a vector-format beat naming a register above 7
   function automatic logic is_illegal(input logic funct, input logic [2:0] opcode,
                                       input logic [3:0] rd);
      return (!funct && opcode == 3'b111) || (!is_scalar(funct, opcode) && rd[3]);
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO used as the encode buffer between the host handshake and
// the instruction memory write port. DEPTH must be a power of two (>=2).
// A push while full or a pop while empty is ignored; clear empties it.
module instr_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = store[rd_ptr];

   // Pointer and occupancy tracking; clear drops every buffered word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Data storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Program-load path: takes decoded instruction fields from the host over a
// valid/ready handshake, packs them into control-unit format, buffers them
// and writes them to instruction memory from address 0 upward.
// Optional macro ENCODE_CHECK_EN: illegal beats are accepted but dropped and
// flagged on the sticky enc_err output (cleared by start).
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid, and the host must hold the beat fields
// stable while in_valid is high and in_ready is low.
module instr_encode_loader
   import vp_isa_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_funct,
   input  logic [2:0]         in_opcode,
   input  logic               in_imm_sel,
   input  logic [1:0]         in_wb,
   input  logic [3:0]         in_rd,
   input  logic [2:0]         in_rs1,
   input  logic [2:0]         in_rs2,
   input  logic [7:0]         in_imm,
   input  logic               in_last,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               busy,
   output logic               done,
   output logic               mem_full,
`ifdef ENCODE_CHECK_EN
   output logic               enc_err,
`endif
   output load_state_t        fsm_state
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   load_state_t        state;
   load_state_t        state_next;
   logic [INSTR_W-1:0] enc_word;
   logic [INSTR_W-1:0] head_word;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_clear;
   logic               accept;
   logic               beat_bad;
   logic               draining;
   logic               last_addr;
   logic               cap_hit;
   logic               session_start;

   assign enc_word = encode_instr(in_funct, in_opcode, in_imm_sel, in_wb,
                                  in_rd, in_rs1, in_rs2, in_imm);

`ifdef ENCODE_CHECK_EN
   assign beat_bad = is_illegal(in_funct, in_opcode, in_rd);
`else
   assign beat_bad = 1'b0;
`endif

   assign session_start = (state == ST_IDLE) && start;
   // One word leaves the buffer every cycle it holds anything during a session
   assign draining      = (state == ST_LOAD || state == ST_FLUSH) && !fifo_empty;
   assign last_addr     = (mem_addr == ADDR_MAX);
   // Writing the top address ends the session; buffered leftovers are dropped
   assign cap_hit       = draining && last_addr;
   assign in_ready      = (state == ST_LOAD) && !fifo_full && !mem_full && !cap_hit;
   assign accept        = in_valid && in_ready;
   assign fifo_push     = accept && !beat_bad;
   assign fifo_pop      = draining;
   assign fifo_clear    = cap_hit || session_start;

   assign mem_we    = draining;
   assign mem_wdata = draining ? head_word : '0;
   assign busy      = (state == ST_LOAD) || (state == ST_FLUSH);
   assign done      = (state == ST_DONE);
   assign fsm_state = state;

   instr_fifo #(
      .WIDTH (INSTR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (fifo_clear),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (enc_word),
      .rdata (head_word),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Session state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Session sequencing: load until the last beat, drain, then pulse done
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_LOAD;
         ST_LOAD: begin
            if (cap_hit)                 state_next = ST_DONE;
            else if (accept && in_last)  state_next = ST_FLUSH;
         end
         ST_FLUSH: if (cap_hit || fifo_empty) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Write address and sticky capacity flag; both restart with a new session
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr <= '0;
         mem_full <= 1'b0;
      end else if (session_start) begin
         mem_addr <= '0;
         mem_full <= 1'b0;
      end else if (draining) begin
         if (last_addr) mem_full <= 1'b1;
         else           mem_addr <= mem_addr + 1'b1;
      end
   end

`ifdef ENCODE_CHECK_EN
   // Sticky illegal-beat flag, cleared when a new session begins
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    enc_err <= 1'b0;
      else if (session_start)     enc_err <= 1'b0;
      else if (accept && beat_bad) enc_err <= 1'b1;
   end
`endif

endmodule
